// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter
// Description : Two-master (CPU = master 0, DMA = master 1) arbiter in front
//               of a single-cycle bus bridge. A three-state FSM
//               (IDLE / OWN0 / OWN1) owns the bus, and the grants are decoded
//               from the registered state, so no req reaches a gnt
//               combinationally. A tenure counter limits how many back-to-back
//               transfers the owner may make while the other master waits.
//               Read data is captured from the bridge at the edge that ends
//               the transfer cycle, so the read latency is one cycle.
// Revision    : 1.0 - initial release
//
// Build option: ARB_ROUND_ROBIN_EN
//   defined   - simultaneous requests in IDLE go to the master that did not
//               own the bus most recently; either owner can be preempted
//   undefined - master 0 wins simultaneous requests; only master 1 can be
//               preempted (it yields to master 0), master 0 never is
//
// Parameters:
//   HOLD_MAX   - max consecutive transfers by one master while the other waits
//
// Ports:
//   cpu_clk              in   sole clock, rising edge
//   cpu_rst              in   asynchronous reset, active low
//   m0_req / m1_req      in   master requests a transfer (held per transfer)
//   mX_addr / mX_wdata   in   [31:0] master address / write data
//   mX_wen               in   master write enable (0 = read)
//   mX_gnt               out  master owns the bus this cycle
//   mX_rdata             out  [31:0] registered read data
//   mX_rvalid            out  mX_rdata valid this cycle
//   Bus_addr / Bus_wdata out  [31:0] address / write data to the bridge
//   Bus_wen              out  write strobe to the bridge
//   Bus_rdata            in   [31:0] combinational read data from the bridge
// ============================================================================
module bus_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,

  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m0_wen,
  output logic        m0_gnt,
  output logic [31:0] m0_rdata,
  output logic        m0_rvalid,

  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_wen,
  output logic        m1_gnt,
  output logic [31:0] m1_rdata,
  output logic        m1_rvalid,

  output logic [31:0] Bus_addr,
  output logic        Bus_wen,
  output logic [31:0] Bus_wdata,
  input  logic [31:0] Bus_rdata
);

  // Counter holds 0..HOLD_MAX-1; keep at least one bit for HOLD_MAX = 1.
  localparam int CNT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CNT_W-1:0] C_TENURE_LAST = CNT_W'(HOLD_MAX - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN0 = 2'd1;
  localparam logic [1:0] S_OWN1 = 2'd2;

  // --------------------------------------------------------------------------
  // State and datapath flops
  // --------------------------------------------------------------------------
  logic [1:0]       state_q,      state_d;
  logic [CNT_W-1:0] tenure_q,     tenure_d;
  logic             last_owner_q, last_owner_d;   // 0 = master 0, 1 = master 1
  logic             m0_rvalid_q,  m0_rvalid_d;
  logic             m1_rvalid_q,  m1_rvalid_d;
  logic [31:0]      m0_rdata_q,   m0_rdata_d;
  logic [31:0]      m1_rdata_q,   m1_rdata_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic       w_xfer0;        // master 0 transfers this cycle
  logic       w_xfer1;        // master 1 transfers this cycle
  logic       w_tenure_last;  // current owner is on its last allowed transfer
  logic [1:0] w_both_pick;    // IDLE winner when both masters request

  // Policy selection. The last-owner flag is tracked in both builds but only
  // steers the IDLE tie-break when round robin is enabled.
`ifdef ARB_ROUND_ROBIN_EN
  localparam logic C_OWN0_PREEMPTIBLE = 1'b1;
  assign w_both_pick = last_owner_q ? S_OWN0 : S_OWN1;
`else
  localparam logic C_OWN0_PREEMPTIBLE = 1'b0;
  assign w_both_pick = S_OWN0;
`endif

  assign w_xfer0       = (state_q == S_OWN0) && m0_req;
  assign w_xfer1       = (state_q == S_OWN1) && m1_req;
  assign w_tenure_last = (tenure_q == C_TENURE_LAST);

  // --------------------------------------------------------------------------
  // Process 1: state register (all flops, asynchronous active-low reset).
  // Resetting state_q to IDLE is what drops Bus_wen and both grants at once,
  // since those outputs are decoded from it.
  // --------------------------------------------------------------------------
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      state_q      <= S_IDLE;
      tenure_q     <= '0;
      last_owner_q <= 1'b1;
      m0_rvalid_q  <= 1'b0;
      m1_rvalid_q  <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      tenure_q     <= tenure_d;
      last_owner_q <= last_owner_d;
      m0_rvalid_q  <= m0_rvalid_d;
      m1_rvalid_q  <= m1_rvalid_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  // --------------------------------------------------------------------------
  // Process 2: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (m0_req && m1_req) begin
          state_d = w_both_pick;
        end else if (m0_req) begin
          state_d = S_OWN0;
        end else if (m1_req) begin
          state_d = S_OWN1;
        end
      end

      S_OWN0: begin
        if (!m0_req) begin
          // Release cycle: no transfer, hand over or fall back to IDLE.
          state_d = m1_req ? S_OWN1 : S_IDLE;
        end else if (m1_req && w_tenure_last && C_OWN0_PREEMPTIBLE) begin
          // Current transfer completes, then the waiting master takes over.
          state_d = S_OWN1;
        end
      end

      S_OWN1: begin
        if (!m1_req) begin
          state_d = m0_req ? S_OWN0 : S_IDLE;
        end else if (m0_req && w_tenure_last) begin
          state_d = S_OWN0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Tenure counter, last-owner flag and read capture. The counter restarts on
  // every ownership change and otherwise counts transfers, sticking at its
  // top value; while the other master is idle it simply stays there.
  always_comb begin
    tenure_d = tenure_q;
    if (state_d != state_q) begin
      tenure_d = '0;
    end else if ((w_xfer0 || w_xfer1) && !w_tenure_last) begin
      tenure_d = tenure_q + CNT_W'(1);
    end

    case (state_d)
      S_OWN0:  last_owner_d = 1'b0;
      S_OWN1:  last_owner_d = 1'b1;
      default: last_owner_d = last_owner_q;
    endcase

    // Read data is sampled at the edge ending a read transfer and is held
    // afterwards; writes never raise rvalid.
    m0_rvalid_d = w_xfer0 && !m0_wen;
    m1_rvalid_d = w_xfer1 && !m1_wen;
    m0_rdata_d  = m0_rvalid_d ? Bus_rdata : m0_rdata_q;
    m1_rdata_d  = m1_rvalid_d ? Bus_rdata : m1_rdata_q;
  end

  // --------------------------------------------------------------------------
  // Process 3: output logic. Grants come purely from the state register; the
  // bus side is driven only during an actual transfer and is zero otherwise
  // (including the release bubble).
  // --------------------------------------------------------------------------
  always_comb begin
    m0_gnt    = (state_q == S_OWN0);
    m1_gnt    = (state_q == S_OWN1);

    Bus_addr  = '0;
    Bus_wdata = '0;
    Bus_wen   = 1'b0;
    if (w_xfer0) begin
      Bus_addr  = m0_addr;
      Bus_wdata = m0_wdata;
      Bus_wen   = m0_wen;
    end else if (w_xfer1) begin
      Bus_addr  = m1_addr;
      Bus_wdata = m1_wdata;
      Bus_wen   = m1_wen;
    end

    m0_rvalid = m0_rvalid_q;
    m1_rvalid = m1_rvalid_q;
    m0_rdata  = m0_rdata_q;
    m1_rdata  = m1_rdata_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arbiter
// Description : Self-checking bench for bus_arbiter. Directed scenarios
//               followed by a randomized run, all compared every cycle
//               against an ownership-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

  localparam int HOLD_MAX = 8;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic        m0_req, m0_wen, m1_req, m1_wen;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] Bus_addr, Bus_wdata, Bus_rdata;
  logic        Bus_wen;

  bus_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
    .cpu_clk   (cpu_clk),
    .cpu_rst   (cpu_rst),
    .m0_req    (m0_req),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_wen    (m0_wen),
    .m0_gnt    (m0_gnt),
    .m0_rdata  (m0_rdata),
    .m0_rvalid (m0_rvalid),
    .m1_req    (m1_req),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_wen    (m1_wen),
    .m1_gnt    (m1_gnt),
    .m1_rdata  (m1_rdata),
    .m1_rvalid (m1_rvalid),
    .Bus_addr  (Bus_addr),
    .Bus_wen   (Bus_wen),
    .Bus_wdata (Bus_wdata),
    .Bus_rdata (Bus_rdata)
  );

  always #5 cpu_clk = ~cpu_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: who owns the bus (-1 none), how many transfers the
  // owner has made, who owned it last, and the expected read-return state.
  int          mdl_own;
  int          mdl_cnt;
  int          mdl_last;
  bit          mdl_rv [2];
  logic [31:0] mdl_rd [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mdl_own  = -1;
    mdl_cnt  = 0;
    mdl_last = 1;
    mdl_rv[0] = 1'b0; mdl_rv[1] = 1'b0;
    mdl_rd[0] = '0;   mdl_rd[1] = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_advance();
    bit req [2];
    bit wen [2];
    int o, other, nxt;
    req[0] = m0_req; req[1] = m1_req;
    wen[0] = m0_wen; wen[1] = m1_wen;
    mdl_rv[0] = 1'b0; mdl_rv[1] = 1'b0;
    if (mdl_own < 0) begin
      if (req[0] && req[1]) nxt = RR ? (1 - mdl_last) : 0;
      else if (req[0])      nxt = 0;
      else if (req[1])      nxt = 1;
      else                  nxt = -1;
    end else begin
      o = mdl_own;
      other = 1 - o;
      if (req[o] && !wen[o]) begin
        mdl_rv[o] = 1'b1;
        mdl_rd[o] = Bus_rdata;
      end
      if (!req[o])
        nxt = req[other] ? other : -1;
      else if (req[other] && (mdl_cnt == HOLD_MAX - 1) && (RR || o == 1))
        nxt = other;
      else
        nxt = o;
      if (nxt == o && req[o] && mdl_cnt < HOLD_MAX - 1) mdl_cnt++;
    end
    if (nxt != mdl_own) mdl_cnt = 0;
    if (nxt >= 0) mdl_last = nxt;
    mdl_own = nxt;
  endtask

  task automatic check_outputs(input string ctx);
    logic [31:0] e_addr, e_wdata;
    logic        e_wen;
    e_addr = '0; e_wdata = '0; e_wen = 1'b0;
    if (mdl_own == 0 && m0_req) begin
      e_addr = m0_addr; e_wdata = m0_wdata; e_wen = m0_wen;
    end else if (mdl_own == 1 && m1_req) begin
      e_addr = m1_addr; e_wdata = m1_wdata; e_wen = m1_wen;
    end
    check({ctx, ":m0_gnt"},    m0_gnt,    (mdl_own == 0));
    check({ctx, ":m1_gnt"},    m1_gnt,    (mdl_own == 1));
    check({ctx, ":gnt_excl"},  m0_gnt & m1_gnt, 0);
    check({ctx, ":Bus_addr"},  Bus_addr,  e_addr);
    check({ctx, ":Bus_wdata"}, Bus_wdata, e_wdata);
    check({ctx, ":Bus_wen"},   Bus_wen,   e_wen);
    check({ctx, ":m0_rvalid"}, m0_rvalid, mdl_rv[0]);
    check({ctx, ":m1_rvalid"}, m1_rvalid, mdl_rv[1]);
    check({ctx, ":m0_rdata"},  m0_rdata,  mdl_rd[0]);
    check({ctx, ":m1_rdata"},  m1_rdata,  mdl_rd[1]);
  endtask

  // Inputs are applied right after a falling edge; outputs are sampled 1 time
  // unit later and the model steps before the next falling edge.
  task automatic settle_check(input string ctx);
    #1;
    check_outputs(ctx);
  endtask

  task automatic advance();
    model_advance();
    @(negedge cpu_clk);
  endtask

  task automatic idle_inputs();
    m0_req = 1'b0; m0_wen = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_wen = 1'b0; m1_addr = '0; m1_wdata = '0;
    Bus_rdata = '0;
  endtask

  initial begin : main
    int hist_bad;
    int m1_xfers;
    bit found;

    // ---------------- reset ----------------
    cpu_rst = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge cpu_clk);
    @(negedge cpu_clk);
    settle_check("reset");
    @(negedge cpu_clk);
    cpu_rst = 1'b1;

    // ---------------- single-master read ----------------
    m0_req = 1'b1; m0_wen = 1'b0; m0_addr = 32'h100; Bus_rdata = 32'hDEADBEEF;
    settle_check("rd_c0");
    check("rd_gnt_latency", m0_gnt, 1'b0);
    advance();
    settle_check("rd_c1");
    check("rd_gnt", m0_gnt, 1'b1);
    check("rd_bus_addr", Bus_addr, 32'h100);
    advance();
    m0_req = 1'b0;
    settle_check("rd_c2");
    check("rd_rvalid", m0_rvalid, 1'b1);
    check("rd_rdata", m0_rdata, 32'hDEADBEEF);
    advance();
    settle_check("rd_c3");
    check("rd_rvalid_drop", m0_rvalid, 1'b0);
    advance();

    // ---------------- master-1 write ----------------
    m1_req = 1'b1; m1_wen = 1'b1; m1_addr = 32'h200; m1_wdata = 32'h12345678;
    Bus_rdata = 32'hA5A5A5A5;
    settle_check("wr_c0");
    advance();
    settle_check("wr_c1");
    check("wr_gnt", m1_gnt, 1'b1);
    check("wr_bus_wen", Bus_wen, 1'b1);
    check("wr_bus_addr", Bus_addr, 32'h200);
    check("wr_bus_wdata", Bus_wdata, 32'h12345678);
    advance();
    m1_req = 1'b0;
    settle_check("wr_c2");
    check("wr_no_rvalid", m1_rvalid, 1'b0);
    check("rdata_hold", m0_rdata, 32'hDEADBEEF);
    advance();
    settle_check("wr_c3");
    advance();

    // ---------------- release with handover ----------------
    m0_req = 1'b1; m0_wen = 1'b1; m0_addr = 32'h300; m0_wdata = 32'h0BADF00D;
    settle_check("rel_c0");
    advance();
    settle_check("rel_c1");
    advance();
    m0_req = 1'b0;
    m1_req = 1'b1; m1_wen = 1'b0; m1_addr = 32'h400; Bus_rdata = 32'h600DCAFE;
    settle_check("rel_bubble");
    check("rel_bubble_wen", Bus_wen, 1'b0);
    check("rel_bubble_addr", Bus_addr, 32'h0);
    check("rel_bubble_m1gnt", m1_gnt, 1'b0);
    advance();
    settle_check("rel_c3");
    check("rel_handover", m1_gnt, 1'b1);
    advance();
    m1_req = 1'b0;
    settle_check("rel_c4");
    advance();
    settle_check("rel_c5");
    advance();

    // ---------------- both requesting continuously ----------------
    // Last owner is master 1, so both builds start with master 0.
    hist_bad = 0;
    m0_req = 1'b1; m1_req = 1'b1; m0_wen = 1'b0; m1_wen = 1'b0;
    for (int k = 0; k < 33; k++) begin
      m0_addr = $urandom; m1_addr = $urandom; Bus_rdata = $urandom;
      settle_check("both");
      if (k >= 1) begin
        if (m0_gnt !== (RR ? (((k - 1) / HOLD_MAX) % 2 == 0) : 1'b1)) hist_bad++;
        if (m1_gnt !== (RR ? (((k - 1) / HOLD_MAX) % 2 == 1) : 1'b0)) hist_bad++;
      end else begin
        if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) hist_bad++;
      end
      advance();
    end
    check("both_gnt_pattern_bad_cycles", hist_bad, 0);

    // ---------------- master 1 must yield to master 0 ----------------
    m0_req = 1'b0; m1_req = 1'b0;
    settle_check("yield_c0");
    advance();
    settle_check("yield_c1");
    advance();
    m1_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle_check("yield_m1only");
      advance();
    end
    m0_req = 1'b1;
    m1_xfers = 0;
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      settle_check("yield_wait");
      if (m0_gnt === 1'b1) found = 1'b1;
      else if (m1_gnt === 1'b1) m1_xfers++;
      advance();
    end
    check("yield_m0_granted", found, 1'b1);
    check("yield_m1_bounded", (m1_xfers <= HOLD_MAX), 1'b1);
    m0_req = 1'b0; m1_req = 1'b0;
    settle_check("yield_end");
    advance();
    settle_check("yield_idle");
    advance();

    // ---------------- asynchronous reset during a write ----------------
    m0_req = 1'b1; m0_wen = 1'b1; m0_addr = 32'h500; m0_wdata = 32'hCAFEBABE;
    settle_check("arst_c0");
    advance();
    settle_check("arst_c1");
    check("arst_pre_wen", Bus_wen, 1'b1);
    #2;
    cpu_rst = 1'b0;
    #1;
    check("arst_wen", Bus_wen, 1'b0);
    check("arst_m0_gnt", m0_gnt, 1'b0);
    check("arst_m1_gnt", m1_gnt, 1'b0);
    check("arst_m0_rvalid", m0_rvalid, 1'b0);
    check("arst_m1_rvalid", m1_rvalid, 1'b0);
    check("arst_addr", Bus_addr, 32'h0);
    model_reset();
    @(negedge cpu_clk);
    idle_inputs();
    cpu_rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle_check("arst_after");
      check("arst_stays_idle", m0_gnt | m1_gnt, 1'b0);
      advance();
    end

    // ---------------- randomized traffic ----------------
    for (int k = 0; k < 500; k++) begin
      m0_req    = ($urandom_range(0, 3) != 0);
      m1_req    = ($urandom_range(0, 3) != 0);
      m0_wen    = $urandom_range(0, 1);
      m1_wen    = $urandom_range(0, 1);
      m0_addr   = $urandom;
      m1_addr   = $urandom;
      m0_wdata  = $urandom;
      m1_wdata  = $urandom;
      Bus_rdata = $urandom;
      settle_check("rand");
      advance();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have one parameter: HOLD_MAX, default 8, maximum consecutive transfers one master may make while the other master is requesting.
REQ-002 cpu_clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-003 cpu_rst  input  1  asynchronous, active-low reset.
REQ-004 m0_req  input  1  master 0 (CPU) requests the bus; held high for every transfer.
REQ-005 m0_addr / m0_wdata  input  32 / 32  master 0 address and write data.
REQ-006 m0_wen  input  1  master 0 write enable (0 = read).
REQ-007 m0_gnt  output  1  master 0 owns the bus this cycle.
REQ-008 m0_rdata  output  32  registered read data for master 0.
REQ-009 m0_rvalid  output  1  m0_rdata is valid this cycle.
REQ-010 m1_req, m1_addr, m1_wdata, m1_wen, m1_gnt, m1_rdata, m1_rvalid SHALL be identical in direction and width for master 1 (DMA).
REQ-011 Bus_addr  output  32  address to the bridge.
REQ-012 Bus_wen  output  1  write strobe to the bridge.
REQ-013 Bus_wdata  output  32  write data to the bridge.
REQ-014 Bus_rdata  input  32  combinational read data from the bridge for the current Bus_addr.

Function
REQ-015 The FSM SHALL have three states: IDLE, OWN0 and OWN1.
REQ-016 m0_gnt SHALL be 1 exactly in OWN0, and m1_gnt SHALL be 1 exactly in OWN1; grant is a decoded state value, with no combinational path from any req to any gnt.
REQ-017 In IDLE with any req high, the next state SHALL be OWN of the selected master, giving a grant latency of one cycle after req is first sampled.
REQ-018 A transfer SHALL occur in each cycle where OWNx holds and mx_req=1.
REQ-019 During a transfer, Bus_addr and Bus_wdata SHALL equal mx_addr and mx_wdata, and Bus_wen SHALL equal mx_wen.
REQ-020 In any other cycle, Bus_addr, Bus_wdata and Bus_wen SHALL all be 0.
REQ-021 For a read transfer (mx_wen=0), Bus_rdata SHALL be captured into mx_rdata at the clock edge, and mx_rvalid SHALL be 1 for exactly the following cycle; read latency is 1.
REQ-022 mx_rdata SHALL hold its value when mx_rvalid=0.
REQ-023 A write transfer SHALL NOT assert rvalid.
REQ-024 A tenure counter SHALL count transfers in the current OWN state, range 0..HOLD_MAX-1.
REQ-025 The tenure counter SHALL clear on every state change.
REQ-026 The tenure counter SHALL saturate at HOLD_MAX-1 while the other master is idle.
REQ-027 In OWNx with mx_req=0, the FSM SHALL go to OWN of the other master if that master's req=1, and to IDLE otherwise.
REQ-028 The cycle in REQ-027 carries no transfer; it is one bubble cycle.
REQ-029 In OWNx with mx_req=1, the other req=1 and the counter=HOLD_MAX-1, the transfer SHALL complete and the FSM SHALL then move to OWN of the other master (preemption).
REQ-030 In all other cases in OWNx, the FSM SHALL remain in OWNx.
REQ-031 A last-owner flag SHALL record the most recent OWN state.
REQ-032 When both reqs are high in IDLE, the selection SHALL follow the arbitration policy in REQ-036/REQ-037.
REQ-033 Dropping a req while not granted SHALL have no effect: no transfer occurs and no state changes.

Reset
REQ-034 When cpu_rst=0, the block SHALL asynchronously force: state IDLE; tenure counter 0; last-owner flag = master 1; m0_gnt, m1_gnt, m0_rvalid and m1_rvalid 0; m0_rdata and m1_rdata 0x00000000; Bus_addr, Bus_wen and Bus_wdata 0.
REQ-035 Reset asserted mid-transfer SHALL drop Bus_wen in the same cycle, with no partial write committed by the arbiter, and an rvalid pending for the next cycle SHALL be discarded.

Configuration
REQ-036 With macro ARB_ROUND_ROBIN_EN defined: simultaneous requests in IDLE SHALL be granted to the master that is not the last owner, and preemption (REQ-029) SHALL apply to both masters.
REQ-037 Without ARB_ROUND_ROBIN_EN: simultaneous requests in IDLE SHALL always grant master 0, preemption SHALL apply only to OWN1 (master 1 yields to master 0), and OWN0 SHALL never be preempted.
REQ-038 The last-owner flag SHALL exist in both builds but affect selection only when ARB_ROUND_ROBIN_EN is defined.

Verification
REQ-039 Reset then single master: m0_req=1, wen=0, addr=0x100, Bus_rdata=0xDEADBEEF -> m0_gnt=1 one cycle later; the first Bus_addr=0x100 at that cycle; m0_rvalid=1 and m0_rdata=0xDEADBEEF the cycle after.
REQ-040 Write: m1 wen=1, addr=0x200, wdata=0x12345678 -> during OWN1, Bus_wen=1, Bus_addr=0x200, Bus_wdata=0x12345678; m1_rvalid stays 0.
REQ-041 Round-robin build, both reqs held continuously from reset with HOLD_MAX=8 -> OWN0 for 8 transfers, then OWN1 for 8, then OWN0, repeating; no cycle has both gnts high.
REQ-042 Fixed-priority build, same stimulus -> m0_gnt stays 1 indefinitely and m1_gnt stays 0; with m1 owning and m0_req rising, OWN1 yields after at most 8 transfers.
REQ-043 Release: m0 owns, m0_req drops while m1_req=1 -> one bubble cycle with Bus_wen=0 and Bus_addr=0, then m1_gnt=1.
REQ-044 Async reset: cpu_rst pulsed low mid-cycle during an m0 write -> Bus_wen, both gnts and both rvalids go 0 immediately; after release with no reqs, the state stays IDLE.
